// File: rtl/sr_cmd_pkg.sv
// rtl/sr_cmd_pkg.sv - shared FSM encodings and limits for the sr_latch command generator
package sr_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DRIVE_SET   = 2'd1,
    DRIVE_RESET = 2'd2,
    HOLDOFF     = 2'd3
  } state_t;

  localparam logic [7:0] CONFLICT_MAX = 8'hFF;

endpackage

// File: rtl/sr_debounce.sv
// rtl/sr_debounce.sv - two-flop synchroniser, stability debouncer and press detector
module sr_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_d1;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
  // The press strobe is registered so downstream sees a clean one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_level    <= 1'b0;
      r_level_d1 <= 1'b0;
      r_rise     <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_sync1    <= din;
      r_sync2    <= r_sync1;
      r_level_d1 <= r_level;
      r_rise     <= r_level & ~r_level_d1;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/sr_cmd_gen.sv
// rtl/sr_cmd_gen.sv - button-to-sr_latch command FSM; SR_CMD_CONFLICT_CNT_EN adds conflict_cnt
module sr_cmd_gen
  import sr_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 2,
  parameter int HOLDOFF_LEN     = 3,
  parameter int SET_PRIORITY    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_btn,
  input  logic       reset_btn,
  output logic       s,
  output logic       r,
  output logic       en,
  output logic       busy
`ifdef SR_CMD_CONFLICT_CNT_EN
  ,
  output logic [7:0] conflict_cnt
`endif
);

  localparam int WMAX = (PULSE_LEN > HOLDOFF_LEN) ? PULSE_LEN : HOLDOFF_LEN;
  localparam int WW   = $clog2(WMAX + 1);
  localparam logic [WW-1:0] PULSE_LAST = WW'(PULSE_LEN - 1);
  localparam logic [WW-1:0] HOLD_LAST  = WW'(HOLDOFF_LEN - 1);

  logic          w_set_req;
  logic          w_reset_req;
  logic          w_set_level;
  logic          w_reset_level;
  logic          w_conflict;
  logic          w_unused;
  state_t        r_state;
  state_t        w_next;
  logic [WW-1:0] r_cnt;
  logic [WW-1:0] w_cnt_next;
  logic          r_s;
  logic          r_r;
  logic          r_en;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
    .clk   (clk),
    .rst   (rst),
    .din   (set_btn),
    .level (w_set_level),
    .rise  (w_set_req)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_db (
    .clk   (clk),
    .rst   (rst),
    .din   (reset_btn),
    .level (w_reset_level),
    .rise  (w_reset_req)
  );

  // Requests outside IDLE are simply ignored; the window counter restarts on every state entry.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt + 1'b1;
    w_conflict = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (w_set_req && w_reset_req) begin
          w_conflict = 1'b1;
          if (SET_PRIORITY != 0) w_next = DRIVE_SET;
        end else if (w_set_req) begin
          w_next = DRIVE_SET;
        end else if (w_reset_req) begin
          w_next = DRIVE_RESET;
        end
      end
      DRIVE_SET, DRIVE_RESET: begin
        if (r_cnt == PULSE_LAST) begin
          w_next     = HOLDOFF;
          w_cnt_next = '0;
        end
      end
      HOLDOFF: begin
        if (r_cnt == HOLD_LAST) begin
          w_next     = IDLE;
          w_cnt_next = '0;
        end
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  // Drive outputs are decoded from the next state so they align with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_s     <= (w_next == DRIVE_SET);
      r_r     <= (w_next == DRIVE_RESET);
      r_en    <= (w_next == DRIVE_SET) || (w_next == DRIVE_RESET);
    end
  end

  assign s    = r_s;
  assign r    = r_r;
  assign en   = r_en;
  assign busy = (r_state != IDLE);

`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [7:0] r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict_cnt <= 8'd0;
    end else if (w_conflict && (r_conflict_cnt != CONFLICT_MAX)) begin
      r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign w_unused     = w_set_level ^ w_reset_level;
`else
  assign w_unused     = w_set_level ^ w_reset_level ^ w_conflict;
`endif

endmodule

// File: tb/tb_sr_cmd_gen.sv
// tb/tb_sr_cmd_gen.sv - scoreboard bench for sr_cmd_gen, both SET_PRIORITY values side by side
module tb_sr_cmd_gen;

  localparam int PULSE_LEN   = 2;
  localparam int HOLDOFF_LEN = 3;
  localparam int LAT         = 8;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic set_btn   = 1'b0;
  logic reset_btn = 1'b0;
  logic s0, r0, en0, busy0;
  logic s1, r1, en1, busy1;
`ifdef SR_CMD_CONFLICT_CNT_EN
  logic [7:0] cc0, cc1;
  localparam int NCONF = 260;
`else
  localparam int NCONF = 3;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    bit is_set;
    int start;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int win_len[2];
  int busy_len[2];
  bit prev_en[2];
  bit prev_busy[2];

  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(PULSE_LEN), .HOLDOFF_LEN(HOLDOFF_LEN),
               .SET_PRIORITY(0)) dut0 (
    .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
    .s(s0), .r(r0), .en(en0), .busy(busy0)
`ifdef SR_CMD_CONFLICT_CNT_EN
    , .conflict_cnt(cc0)
`endif
  );

  sr_cmd_gen #(.DEBOUNCE_CYCLES(4), .PULSE_LEN(PULSE_LEN), .HOLDOFF_LEN(HOLDOFF_LEN),
               .SET_PRIORITY(1)) dut1 (
    .clk(clk), .rst(rst), .set_btn(set_btn), .reset_btn(reset_btn),
    .s(s1), .r(r1), .en(en1), .busy(busy1)
`ifdef SR_CMD_CONFLICT_CNT_EN
    , .conflict_cnt(cc1)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int d, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%0d required=%0d cyc=%0d", name, d, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input bit is_set, input int start);
    exp_t e;
    e.is_set = is_set;
    e.start  = start;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(input int d, input logic sv, input logic rv, input logic env, input logic bv);
    exp_t e;
    int   sz;
    chk("no_s_and_r", d, int'(sv & rv), 0);
    chk("en_eq_s_or_r", d, int'(env), int'(sv | rv));
    if (rst) begin
      chk("reset_outputs", d, int'({sv, rv, env, bv}), 0);
      win_len[d]   = 0;
      busy_len[d]  = 0;
      prev_en[d]   = 1'b0;
      prev_busy[d] = 1'b0;
    end else begin
      if (env && !prev_en[d]) begin
        sz = (d == 0) ? q0.size() : q1.size();
        chk("drive_expected", d, int'(sz > 0), 1);
        if (sz > 0) begin
          if (d == 0) e = q0.pop_front();
          else e = q1.pop_front();
          chk("drive_kind_s", d, int'(sv), int'(e.is_set));
          chk("drive_start", d, cyc, e.start);
        end
      end
      if (env) begin
        win_len[d]++;
        chk("busy_in_drive", d, int'(bv), 1);
      end else if (prev_en[d]) begin
        chk("drive_len", d, win_len[d], PULSE_LEN);
        win_len[d] = 0;
      end
      if (bv) begin
        busy_len[d]++;
      end else if (prev_busy[d]) begin
        chk("busy_len", d, busy_len[d], PULSE_LEN + HOLDOFF_LEN);
        busy_len[d] = 0;
      end
      prev_en[d]   = env;
      prev_busy[d] = bv;
    end
  endtask

  always begin
    @(posedge clk);
    #2;
    mon(0, s0, r0, en0, busy0);
    mon(1, s1, r1, en1, busy1);
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    wait_neg(20);
    chk({name, "_q_empty"}, 0, q0.size(), 0);
    chk({name, "_q_empty"}, 1, q1.size(), 0);
  endtask

  initial begin
    int t0;
    int exp_cc;
    wait_neg(3);
    rst = 1'b0;
    wait_neg(2);

    // single set press
    t0 = cyc;
    set_btn = 1'b1;
    push(0, 1'b1, t0 + LAT);
    push(1, 1'b1, t0 + LAT);
    wait_neg(12);
    set_btn = 1'b0;
    drain("set_press");

    // single reset press
    t0 = cyc;
    reset_btn = 1'b1;
    push(0, 1'b0, t0 + LAT);
    push(1, 1'b0, t0 + LAT);
    wait_neg(12);
    reset_btn = 1'b0;
    drain("reset_press");

    // bounce shorter than the debounce interval
    for (int i = 0; i < 7; i++) begin
      set_btn = (i % 2 == 0);
      wait_neg(2);
    end
    set_btn = 1'b0;
    drain("bounce");

    // reset press arriving during the set window is dropped
    t0 = cyc;
    set_btn = 1'b1;
    push(0, 1'b1, t0 + LAT);
    push(1, 1'b1, t0 + LAT);
    wait_neg(1);
    reset_btn = 1'b1;
    wait_neg(12);
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    drain("busy_drop");

    // rst during first drive cycle, button still held
    t0 = cyc;
    set_btn = 1'b1;
    push(0, 1'b1, t0 + LAT);
    push(1, 1'b1, t0 + LAT);
    push(0, 1'b1, t0 + LAT + 9);
    push(1, 1'b1, t0 + LAT + 9);
    wait_neg(LAT);
    rst = 1'b1;
    wait_neg(1);
    chk("abort_s", 0, int'(s0), 0);
    chk("abort_en", 0, int'(en0), 0);
    chk("abort_busy", 0, int'(busy0), 0);
    chk("abort_s", 1, int'(s1), 0);
    rst = 1'b0;
    wait_neg(20);
    set_btn = 1'b0;
    drain("rst_abort");

    // simultaneous press
    t0 = cyc;
    set_btn   = 1'b1;
    reset_btn = 1'b1;
    push(1, 1'b1, t0 + LAT);
    wait_neg(12);
    set_btn   = 1'b0;
    reset_btn = 1'b0;
    drain("conflict");
`ifdef SR_CMD_CONFLICT_CNT_EN
    chk("conflict_cnt_one", 0, int'(cc0), 1);
    chk("conflict_cnt_one", 1, int'(cc1), 1);
`endif

    // repeated simultaneous presses
    for (int i = 0; i < NCONF; i++) begin
      t0 = cyc;
      set_btn   = 1'b1;
      reset_btn = 1'b1;
      push(1, 1'b1, t0 + LAT);
      wait_neg(8);
      set_btn   = 1'b0;
      reset_btn = 1'b0;
      wait_neg(8);
    end
    drain("conflict_burst");
    exp_cc = (NCONF + 1 > 255) ? 255 : NCONF + 1;
`ifdef SR_CMD_CONFLICT_CNT_EN
    chk("conflict_cnt_sat", 0, int'(cc0), exp_cc);
    chk("conflict_cnt_sat", 1, int'(cc1), exp_cc);
`else
    chk("conflict_burst_idle", 0, int'(busy0), exp_cc - NCONF - 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
